mesi_snoop_cache: RTL
=====================

MESI_SNOOP_CACHE -- requirements
Module: mesi_snoop_cache

Interface
REQ-001 Parameter LINES, 4, number of direct-mapped lines (power of two, >=2).
REQ-002 Parameter ADDR_W, 5, address width; index = low log2(LINES) bits, tag = remaining bits.
REQ-003 Parameter DATA_W, 8, data word width.
REQ-004 clock  in  1  rising-edge clock, sole clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cpu_req in 1 request valid; cpu_we in 1 write=1/read=0; cpu_addr in ADDR_W; cpu_wdata in DATA_W.
REQ-007 cpu_ack out 1 one-cycle completion pulse; cpu_rdata out DATA_W read data, valid with cpu_ack.
REQ-008 bus_req out 1 bus request; bus_gnt in 1 bus grant.
REQ-009 bus_cmd out 2 command: 0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr; bus_addr out ADDR_W.
REQ-010 bus_wb out 1 writeback strobe; bus_wdata out DATA_W writeback data.
REQ-011 mem_valid in 1, mem_rdata in DATA_W: fill data; snp_shared_in in 1: another cache holds the line.
REQ-012 snp_valid in 1, snp_cmd in 2, snp_addr in ADDR_W: foreign bus transaction.
REQ-013 snp_hit out 1 this cache holds snooped line; snp_abort out 1 this cache supplies dirty data, memory response suppressed.

Function
REQ-014 Line state encoding SHALL be I=0, S=1, M=2, E=3; each line holds tag, state, data.
REQ-015 FSM states SHALL be IDLE, ARB, WB, FILL, DONE.
REQ-016 IDLE samples cpu_req; hit = state!=I and tag match.
REQ-017 Read hit (S/E/M), write hit (M), write hit (E->M, data written): cpu_ack and cpu_rdata SHALL be registered one cycle after sampling; no bus activity.
REQ-018 Write hit in S SHALL go to ARB with bus_cmd=3; after grant one cycle of BusUpgr, line->M, data written, DONE.
REQ-019 Miss SHALL go to ARB, bus_req=1 held until bus_gnt; bus_cmd/bus_addr held stable from ARB entry.
REQ-020 Miss with M victim: after grant, WB asserts bus_wb one cycle with victim address (victim tag + index) and data, then issues BusRd (read) or BusRdX (write).
REQ-021 FILL waits on mem_valid unbounded; read fill -> S if snp_shared_in sampled with mem_valid, else E; write fill -> M with cpu_wdata merged.
REQ-022 DONE SHALL pulse cpu_ack, drop bus_req, return to IDLE; cpu_rdata = filled data for reads.
REQ-023 Snoop evaluated every cycle snp_valid=1 while bus_gnt=0; outputs snp_hit/snp_abort registered, one cycle later.
REQ-024 Snoop BusRd hit: M -> S with bus_wb+bus_wdata+snp_abort; E -> S; S stays S.
REQ-025 Snoop BusRdX hit: M -> I with bus_wb+snp_abort; S/E -> I. Snoop BusUpgr hit: S -> I.
REQ-026 Snoop invalidating the line during own pending BusUpgr (ARB, no grant) SHALL convert bus_cmd to 2 (BusRdX) and follow the miss path.
REQ-027 Snoop and CPU access to the same line in the same cycle: snoop state update SHALL apply first; CPU lookup uses the updated state.
REQ-028 cpu_req ignored outside IDLE; one outstanding request only.

Reset
REQ-029 reset SHALL set all line states I, tags and data 0, FSM IDLE, all outputs 0.
REQ-030 reset mid-transaction SHALL drop bus_req/bus_wb at the next edge and SHALL NOT produce cpu_ack.

Configuration
REQ-031 Macro MESI_EXCLUSIVE_EN defined: E state used as in REQ-021/024.
REQ-032 MESI_EXCLUSIVE_EN undefined (MSI mode): read fills SHALL always enter S; state 3 never produced; write hit in S still uses BusUpgr.

Verification
REQ-033 Reset, read addr 5'h0A, gnt, mem_rdata=8'h3C, snp_shared_in=0 -> bus_cmd=1, line->E (S when macro off), cpu_ack with cpu_rdata=8'h3C.
REQ-034 Then write 8'h77 to 5'h0A -> cpu_ack next cycle, no bus_req, line->M.
REQ-035 Then read 5'h0E (same index, LINES=4) -> bus_wb with bus_addr=5'h0A, bus_wdata=8'h77, then BusRd.
REQ-036 Line S, write hit, snoop BusUpgr same line before grant -> bus_cmd changes 3->2, fill path, line ends M.
REQ-037 Line M data 8'h55, snoop BusRd same addr -> next cycle snp_hit=1, snp_abort=1, bus_wb=1, bus_wdata=8'h55, line->S.
REQ-038 reset asserted during FILL -> bus_req=0 next cycle, no cpu_ack, all lines I.

Source files
------------

// File: rtl/mesi_snoop_cache_if.sv
// mesi_snoop_cache_if: CPU request, shared-bus and snoop signals of mesi_snoop_cache.
// slave is the cache side, master is the CPU/bus/memory environment.
interface mesi_snoop_cache_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              bus_req;
  logic              bus_gnt;
  logic [1:0]        bus_cmd;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_wb;
  logic [DATA_W-1:0] bus_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              snp_shared_in;
  logic              snp_valid;
  logic [1:0]        snp_cmd;
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_hit;
  logic              snp_abort;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_gnt, mem_valid, mem_rdata,
           snp_shared_in, snp_valid, snp_cmd, snp_addr,
    output cpu_ack, cpu_rdata, bus_req, bus_cmd, bus_addr, bus_wb, bus_wdata, snp_hit, snp_abort
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, bus_gnt, mem_valid, mem_rdata,
           snp_shared_in, snp_valid, snp_cmd, snp_addr,
    input  cpu_ack, cpu_rdata, bus_req, bus_cmd, bus_addr, bus_wb, bus_wdata, snp_hit, snp_abort
  );
endinterface

// File: rtl/mesi_snoop_cache.sv
// mesi_snoop_cache: direct-mapped snooping cache controller, MESI with MESI_EXCLUSIVE_EN defined, MSI otherwise.
// Snoops update line state before the CPU lookup of the same cycle.
module mesi_snoop_cache #(
  parameter int LINES  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input logic clock,
  input logic reset,
  mesi_snoop_cache_if.slave bus
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [1:0] CMD_NONE = 2'd0, CMD_RD = 2'd1, CMD_RDX = 2'd2, CMD_UPGR = 2'd3;
`ifdef MESI_EXCLUSIVE_EN
  localparam bit EXCL = 1'b1;
`else
  localparam bit EXCL = 1'b0;
`endif
  typedef enum logic [1:0] {ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2, ST_E = 2'd3} line_st_t;
  typedef enum logic [2:0] {IDLE, ARB, WB, FILL, DONE} fsm_t;
  line_st_t          line_state [LINES];
  logic [TAG_W-1:0]  line_tag   [LINES];
  logic [DATA_W-1:0] line_data  [LINES];
  fsm_t              fsm;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [IDX_W-1:0]  s_idx, c_idx, r_idx;
  logic [TAG_W-1:0]  s_tag, c_tag, r_tag;
  logic              snp_hit_c, snp_dirty, c_hit, upgr_lost;
  line_st_t          snp_next, c_state;
  always_comb begin
    s_idx     = bus.snp_addr[IDX_W-1:0];
    s_tag     = bus.snp_addr[ADDR_W-1:IDX_W];
    c_idx     = bus.cpu_addr[IDX_W-1:0];
    c_tag     = bus.cpu_addr[ADDR_W-1:IDX_W];
    r_idx     = req_addr[IDX_W-1:0];
    r_tag     = req_addr[ADDR_W-1:IDX_W];
    snp_hit_c = bus.snp_valid && !bus.bus_gnt && bus.snp_cmd != CMD_NONE &&
                line_state[s_idx] != ST_I && line_tag[s_idx] == s_tag;
    snp_dirty = snp_hit_c && line_state[s_idx] == ST_M && bus.snp_cmd != CMD_UPGR;
    snp_next  = bus.snp_cmd == CMD_RD  ? ST_S :
                bus.snp_cmd == CMD_RDX ? ST_I :
                line_state[s_idx] == ST_S ? ST_I : line_state[s_idx];
    c_state   = (snp_hit_c && s_idx == c_idx) ? snp_next : line_state[c_idx];
    c_hit     = c_state != ST_I && line_tag[c_idx] == c_tag;
    upgr_lost = snp_hit_c && s_idx == r_idx && snp_next == ST_I;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        line_state[i] <= ST_I;
        line_tag[i]   <= '0;
        line_data[i]  <= '0;
      end
      fsm           <= IDLE;
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_wdata     <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_cmd   <= CMD_NONE;
      bus.bus_addr  <= '0;
      bus.bus_wb    <= 1'b0;
      bus.bus_wdata <= '0;
      bus.snp_hit   <= 1'b0;
      bus.snp_abort <= 1'b0;
    end else begin
      bus.cpu_ack   <= 1'b0;
      bus.bus_wb    <= snp_dirty;
      bus.snp_hit   <= snp_hit_c;
      bus.snp_abort <= snp_dirty;
      if (snp_hit_c) line_state[s_idx] <= snp_next;
      if (snp_dirty) bus.bus_wdata <= line_data[s_idx];
      case (fsm)
        IDLE: if (bus.cpu_req) begin
          req_we    <= bus.cpu_we;
          req_addr  <= bus.cpu_addr;
          req_wdata <= bus.cpu_wdata;
          if (c_hit && (!bus.cpu_we || c_state != ST_S)) begin
            bus.cpu_ack   <= 1'b1;
            bus.cpu_rdata <= bus.cpu_we ? bus.cpu_wdata : line_data[c_idx];
            if (bus.cpu_we) begin
              line_state[c_idx] <= ST_M;
              line_data[c_idx]  <= bus.cpu_wdata;
            end
          end else begin
            fsm          <= ARB;
            bus.bus_req  <= 1'b1;
            bus.bus_addr <= bus.cpu_addr;
            bus.bus_cmd  <= c_hit ? CMD_UPGR : bus.cpu_we ? CMD_RDX : CMD_RD;
          end
        end
        ARB: if (bus.bus_gnt) begin
          if (bus.bus_cmd == CMD_UPGR) begin
            line_state[r_idx] <= ST_M;
            line_data[r_idx]  <= req_wdata;
            bus.cpu_ack       <= 1'b1;
            bus.cpu_rdata     <= req_wdata;
            bus.bus_req       <= 1'b0;
            bus.bus_cmd       <= CMD_NONE;
            fsm               <= DONE;
          end else if (line_state[r_idx] == ST_M) begin
            bus.bus_wb    <= 1'b1;
            bus.bus_addr  <= {line_tag[r_idx], r_idx};
            bus.bus_wdata <= line_data[r_idx];
            fsm           <= WB;
          end else fsm <= FILL;
        end else if (bus.bus_cmd == CMD_UPGR && upgr_lost) bus.bus_cmd <= CMD_RDX;
        WB: begin
          bus.bus_addr <= req_addr;
          fsm          <= FILL;
        end
        FILL: if (bus.mem_valid) begin
          line_tag[r_idx]   <= r_tag;
          line_state[r_idx] <= req_we ? ST_M : (EXCL && !bus.snp_shared_in) ? ST_E : ST_S;
          line_data[r_idx]  <= req_we ? req_wdata : bus.mem_rdata;
          bus.cpu_ack       <= 1'b1;
          bus.cpu_rdata     <= req_we ? req_wdata : bus.mem_rdata;
          bus.bus_req       <= 1'b0;
          bus.bus_cmd       <= CMD_NONE;
          fsm               <= DONE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
